// File: rtl/sqd_pkg.sv
// Shared types and constants for the sqd detector scheduler.
// The residue step function mirrors what the external detector computes per bit.
package sqd_pkg;

  localparam int WORD_W_DEF = 8;
  localparam int ID_W       = 1;

  localparam logic [1:0] R0 = 2'd0;
  localparam logic [1:0] R1 = 2'd1;
  localparam logic [1:0] R2 = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2,
    RESP  = 2'd3
  } state_t;

  // One MSB-first step of a mod-3 residue: r' = (2r + x) mod 3.
  function automatic logic [1:0] res_step(input logic [1:0] r, input logic x);
    logic [1:0] n;
    n = R0;
    case (r)
      R0:      n = x ? R1 : R0;
      R1:      n = x ? R0 : R2;
      R2:      n = x ? R2 : R1;
      default: n = R0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/sqd_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins,
// and on contention the pointer decides.
module sqd_rr_arb2
  import sqd_pkg::*;
(
  input  logic [1:0]      valid,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] grant_id,
  output logic            grant_valid
);

  always_comb begin
    grant_valid = |valid;
    grant_id    = ptr;
    if (valid == 2'b01) begin
      grant_id = 1'b0;
    end else if (valid == 2'b10) begin
      grant_id = 1'b1;
    end
  end

endmodule

// File: rtl/sqd_sched.sv
// Schedules two requesters onto one serial mod-3 detector: clear it, shift a word
// in MSB first, then hold the detector's residue (checked against a local model).
module sqd_sched
  import sqd_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [WORD_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [WORD_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              det_clr,
  output logic              det_x,
  input  logic [1:0]        det_z,
  output logic              rsp_valid,
  output logic [ID_W-1:0]   rsp_id,
  output logic [1:0]        rsp_rem,
  output logic              rsp_err,
  input  logic              rsp_ready
);

  localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr;
  logic [WORD_W-1:0] shreg;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        res_q, res_next;
  logic [ID_W-1:0]   rsp_id_q;
  logic [1:0]        rsp_rem_q;
  logic              rsp_err_q;
  logic [ID_W-1:0]   grant_id;
  logic              grant_valid;
  logic              last_bit;

  sqd_rr_arb2 u_arb (
    .valid       ({req1_valid, req0_valid}),
    .ptr         (rr_ptr),
    .grant_id    (grant_id),
    .grant_valid (grant_valid)
  );

  assign last_bit = (state_q == SHIFT) && (cnt == CNT_LAST);
  assign res_next = res_step(res_q, shreg[WORD_W-1]);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_valid) state_d = CLEAR;
      CLEAR:   state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // While reset is held the outputs are forced to their idle values,
  // independent of whatever the registers hold before the first edge.
  always_comb begin
    req0_ready = reset && (state_q == IDLE) && grant_valid && (grant_id == 1'b0);
    req1_ready = reset && (state_q == IDLE) && grant_valid && (grant_id == 1'b1);
    det_clr    = !reset || (state_q == CLEAR);
    det_x      = reset && (state_q == SHIFT) && shreg[WORD_W-1];
    rsp_valid  = reset && (state_q == RESP);
    rsp_id     = reset ? rsp_id_q  : '0;
    rsp_rem    = reset ? rsp_rem_q : R0;
    rsp_err    = reset && rsp_err_q;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rr_ptr    <= '0;
      shreg     <= '0;
      cnt       <= '0;
      res_q     <= R0;
      rsp_id_q  <= '0;
      rsp_rem_q <= R0;
      rsp_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            shreg    <= (grant_id == 1'b1) ? req1_data : req0_data;
            rsp_id_q <= grant_id;
          end
        end
        CLEAR: begin
          cnt   <= '0;
          res_q <= R0;
        end
        SHIFT: begin
          shreg <= shreg << 1;
          cnt   <= cnt + CNT_W'(1);
          res_q <= res_next;
          if (last_bit) begin
            rsp_rem_q <= det_z;
            rsp_err_q <= (res_next != det_z);
          end
        end
        RESP: begin
          if (rsp_ready) rr_ptr <= ~rsp_id_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sqd_sched.md
SQD_SCHED -- requirements
Module: sqd_sched

Interface
REQ-001 Parameter WORD_W, default 8, width in bits of each request word shifted through the detector.
REQ-002 clock  input  1  the single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clock.
REQ-004 req0_valid / req1_valid  input  1 each  requester N offers a word.
REQ-005 req0_data / req1_data  input  WORD_W each  word offered, shifted MSB first.
REQ-006 req0_ready / req1_ready  output  1 each  word accepted when valid and ready are both high on the same edge.
REQ-007 det_clr  output  1  active-high clear to the external sqd detector's reset input.
REQ-008 det_x  output  1  serial bit driven to the detector's input_x.
REQ-009 det_z  input  2  detector's output_z, which is its combinational next state (residue 0/1/2).
REQ-010 rsp_valid  output  1  result available.
REQ-011 rsp_id  output  1  requester that owns the result.
REQ-012 rsp_rem  output  2  residue of the word mod 3, as reported by the detector.
REQ-013 rsp_err  output  1  detector result disagrees with the internal residue model.
REQ-014 rsp_ready  input  1  consumer accepts the result when high together with rsp_valid.

Function
REQ-015 The block SHALL be an FSM with states IDLE, CLEAR, SHIFT and RESP.
REQ-016 IDLE: no valid -> stay; any valid -> grant one requester, latch its word and its id, go to CLEAR.
REQ-017 Grant: only one valid -> that one; both valid -> the requester selected by the round-robin pointer.
REQ-018 reqN_ready SHALL be high combinationally only in IDLE and only for the granted N; never both high.
REQ-019 CLEAR: det_clr=1 and det_x=0 for exactly one cycle, then go to SHIFT.
REQ-020 SHIFT: lasts exactly WORD_W cycles; det_x = MSB of the shift register; the register shifts left by one per cycle; a bit counter runs 0..WORD_W-1.
REQ-021 In the SHIFT cycle with counter = WORD_W-1, det_z SHALL be captured into rsp_rem before the edge, and the FSM goes to RESP.
REQ-022 Internal model: the residue r starts at 0 in CLEAR and is updated each SHIFT cycle as r' = (2r + det_x) mod 3; rsp_err = (final r' != captured det_z).
REQ-023 RESP: rsp_valid=1 with rsp_id, rsp_rem and rsp_err held stable until rsp_ready=1.
REQ-024 On the RESP handshake: go to IDLE, point the round-robin pointer at the other requester, drop rsp_valid.
REQ-025 Latency: accept at edge A; CLEAR in cycle A+1; SHIFT in cycles A+2..A+WORD_W+1; rsp_valid from cycle A+WORD_W+2.
REQ-026 A new request SHALL NOT be accepted while in CLEAR, SHIFT or RESP; requester valid/data changes in those states are ignored.
REQ-027 det_clr SHALL be 0 outside CLEAR and outside reset; det_x SHALL be 0 outside SHIFT.
REQ-028 rsp_ready asserted with rsp_valid low SHALL have no effect.

Reset
REQ-029 While reset=0 on an edge: state=IDLE, round-robin pointer=requester 0, shift register, counter and residue=0.
REQ-030 Output values while reset=0: rsp_valid=0, rsp_rem=0, rsp_err=0, rsp_id=0, req0/1_ready=0, det_x=0, det_clr=1.
REQ-031 Reset asserted mid-SHIFT or mid-RESP SHALL abandon the word with no response.
REQ-032 The first grant after reset is deasserted SHALL favour requester 0.

Structure
REQ-033 Shared package sqd_pkg: FSM state encoding, WORD_W default, requester-id width, and residue constants R0=0, R1=1, R2=2.
REQ-034 The two-way round-robin grant logic SHALL be one sub-module, sqd_rr_arb2 (inputs: valids and pointer; output: grant id and grant valid).

Verification (bench instantiates the sqd detector wired to det_clr/det_x/det_z)
REQ-035 req0 offers 8'h07 with rsp_ready=1 -> 10 cycles after accept: rsp_valid=1, rsp_id=0, rsp_rem=1, rsp_err=0.
REQ-036 Sequential words 8'hFF, 8'h05, 8'h00 -> rsp_rem = 0, 2, 0 respectively.
REQ-037 Both requesters valid right after reset (req0=8'h03, req1=8'h04) -> req0 served first with rem=0, then req1 with rem=1; pointer alternates.
REQ-038 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid and its fields stay stable; req0/1_ready stay 0; nothing is accepted.
REQ-039 reset=0 in the 4th SHIFT cycle -> next cycle: IDLE, det_clr=1, rsp_valid=0; a fresh request then completes normally.
REQ-040 Bench forces det_z=2'b00 for word 8'h07 -> rsp_rem=0 and rsp_err=1.
